// File: rtl/sram_arbiter_if.sv
// Requester-side and SRAM-controller-side signals of the two-port SRAM arbiter.
interface sram_arbiter_if;
    logic        req0_rd;
    logic        req0_wr;
    logic [31:0] req0_addr;
    logic [31:0] req0_wdata;
    logic [63:0] req0_rdata;
    logic        req0_ready;
    logic        req0_done;

    logic        req1_rd;
    logic        req1_wr;
    logic [31:0] req1_addr;
    logic [31:0] req1_wdata;
    logic [63:0] req1_rdata;
    logic        req1_ready;
    logic        req1_done;

    logic        mem_rd_en;
    logic        mem_wr_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic        mem_ready;

    // Arbiter side
    modport slave (
        input  req0_rd, req0_wr, req0_addr, req0_wdata,
        output req0_rdata, req0_ready, req0_done,
        input  req1_rd, req1_wr, req1_addr, req1_wdata,
        output req1_rdata, req1_ready, req1_done,
        output mem_rd_en, mem_wr_en, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    // Requesters plus SRAM controller side
    modport master (
        output req0_rd, req0_wr, req0_addr, req0_wdata,
        input  req0_rdata, req0_ready, req0_done,
        output req1_rd, req1_wr, req1_addr, req1_wdata,
        input  req1_rdata, req1_ready, req1_done,
        input  mem_rd_en, mem_wr_en, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one SRAM controller between two requesters.
// One transaction at a time: IDLE -> BUSY (until mem_ready or timeout) -> RELEASE.
module sram_arbiter #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 8
) (
    input  logic           clk,
    input  logic           reset,
    sram_arbiter_if.slave  bus,
    output logic [1:0]     grant,
    output logic           err_timeout
);
    typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

    state_t           state, state_nxt;
    logic             req0, req1;
    logic             take, pick1, finish, timed_out;
    logic             last_grant;      // index of the most recently granted port
    logic             op_wr;
    logic [CNT_W-1:0] cnt;
    logic [63:0]      rdata0, rdata1;
    logic             done0, done1;
    logic             rd_en, wr_en;
    logic [31:0]      addr_q, wdata_q;

    assign req0 = bus.req0_rd | bus.req0_wr;
    assign req1 = bus.req1_rd | bus.req1_wr;

    assign bus.req0_rdata = rdata0;
    assign bus.req1_rdata = rdata1;
    assign bus.req0_done  = done0;
    assign bus.req1_done  = done1;
    assign bus.req0_ready = ~req0 | done0;
    assign bus.req1_ready = ~req1 | done1;
    assign bus.mem_rd_en  = rd_en;
    assign bus.mem_wr_en  = wr_en;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = wdata_q;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state and arbitration decision; ready has priority over timeout
    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        pick1     = 1'b0;
        finish    = 1'b0;
        timed_out = 1'b0;
        case (state)
            IDLE: begin
                if (req0 | req1) begin
                    take      = 1'b1;
                    pick1     = req1 & (~req0 | ~last_grant);
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (bus.mem_ready) begin
                    finish    = 1'b1;
                    state_nxt = RELEASE;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    finish    = 1'b1;
                    timed_out = 1'b1;
                    state_nxt = RELEASE;
                end
            end
            RELEASE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Latched transaction, enables, completion pulses, read results and error flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant       <= 2'b00;
            last_grant  <= 1'b1;
            op_wr       <= 1'b0;
            rd_en       <= 1'b0;
            wr_en       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt         <= '0;
            done0       <= 1'b0;
            done1       <= 1'b0;
            rdata0      <= '0;
            rdata1      <= '0;
            err_timeout <= 1'b0;
        end else begin
            done0 <= 1'b0;
            done1 <= 1'b0;
            if (state == BUSY) cnt <= cnt + CNT_W'(1);
            if (take) begin
                grant      <= pick1 ? 2'b10 : 2'b01;
                last_grant <= pick1;
                op_wr      <= pick1 ? bus.req1_wr : bus.req0_wr;
                wr_en      <= pick1 ? bus.req1_wr : bus.req0_wr;
                rd_en      <= pick1 ? ~bus.req1_wr : ~bus.req0_wr;
                addr_q     <= pick1 ? bus.req1_addr : bus.req0_addr;
                wdata_q    <= pick1 ? bus.req1_wdata : bus.req0_wdata;
                cnt        <= '0;
            end
            if (finish) begin
                grant <= 2'b00;
                rd_en <= 1'b0;
                wr_en <= 1'b0;
                cnt   <= '0;
                done0 <= grant[0];
                done1 <= grant[1];
                if (timed_out) begin
                    err_timeout <= 1'b1;
                end else if (!op_wr) begin
                    if (grant[0]) rdata0 <= bus.mem_rdata;
                    if (grant[1]) rdata1 <= bus.mem_rdata;
                end
            end
        end
    end
endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed scenarios followed by randomized
// traffic, compared against a transaction-level model of arbitration and completion.
`timescale 1ns/1ps
module tb_sram_arbiter;
    localparam int TIMEOUT = 15;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] grant;
    logic       err_timeout;

    sram_arbiter_if bus();

    sram_arbiter #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave),
        .grant(grant),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Transaction-level model state
    int          last_port;
    logic [63:0] exp_rdata [2];
    logic        exp_err;
    logic [1:0]  obs_grant;

    // Requester intent
    logic        p_rd [2];
    logic        p_wr [2];
    logic [31:0] p_addr [2];
    logic [31:0] p_wdata [2];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reqs();
        bus.req0_rd    = p_rd[0];
        bus.req0_wr    = p_wr[0];
        bus.req0_addr  = p_addr[0];
        bus.req0_wdata = p_wdata[0];
        bus.req1_rd    = p_rd[1];
        bus.req1_wr    = p_wr[1];
        bus.req1_addr  = p_addr[1];
        bus.req1_wdata = p_wdata[1];
    endtask

    function automatic logic pend(input int p);
        return p_rd[p] | p_wr[p];
    endfunction

    function automatic logic get_done(input int p);
        return (p == 1) ? bus.req1_done : bus.req0_done;
    endfunction

    function automatic logic get_ready(input int p);
        return (p == 1) ? bus.req1_ready : bus.req0_ready;
    endfunction

    task automatic clear_port(input int p);
        p_rd[p] = 1'b0; p_wr[p] = 1'b0; p_addr[p] = '0; p_wdata[p] = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_grant"}, 64'(grant), 64'd0);
        check({tag, "_rd_en"}, 64'(bus.mem_rd_en), 64'd0);
        check({tag, "_wr_en"}, 64'(bus.mem_wr_en), 64'd0);
        check({tag, "_done0"}, 64'(bus.req0_done), 64'd0);
        check({tag, "_done1"}, 64'(bus.req1_done), 64'd0);
        check({tag, "_err"}, 64'(err_timeout), 64'd0);
        check({tag, "_addr"}, 64'(bus.mem_addr), 64'd0);
        check({tag, "_wdata"}, 64'(bus.mem_wdata), 64'd0);
        check({tag, "_rdata0"}, bus.req0_rdata, 64'd0);
        check({tag, "_rdata1"}, bus.req1_rdata, 64'd0);
    endtask

    // Asserts reset mid-cycle, checks the cleared outputs, releases away from the edge
    task automatic do_reset(input string tag);
        reset = 1'b1;
        bus.mem_ready = 1'b0;
        #1;
        check_all_zero(tag);
        @(negedge clk);
        reset = 1'b0;
        last_port    = 1;
        exp_rdata[0] = '0;
        exp_rdata[1] = '0;
        exp_err      = 1'b0;
    endtask

    // One full transaction, entered during an IDLE cycle with requests applied.
    // lat = BUSY cycle on which the controller raises ready (0 = never).
    task automatic run_txn(input string tag, input int lat, input int drop_at, input logic [63:0] rdv);
        int          w, n;
        logic        wr, timed, fin, rdy;
        logic [31:0] a, d;
        w = (pend(0) && pend(1)) ? (1 - last_port) : (pend(0) ? 0 : 1);
        last_port = w;
        wr = p_wr[w];
        a  = p_addr[w];
        d  = p_wdata[w];
        n   = 0;
        fin = 1'b0;
        while (!fin) begin
            tick();
            n++;
            if (n == 1) obs_grant = grant;
            check({tag, "_grant"}, 64'(grant), (w == 1) ? 64'd2 : 64'd1);
            check({tag, "_wr_en"}, 64'(bus.mem_wr_en), 64'(wr));
            check({tag, "_rd_en"}, 64'(bus.mem_rd_en), 64'(!wr));
            check({tag, "_addr"}, 64'(bus.mem_addr), 64'(a));
            check({tag, "_wdata"}, 64'(bus.mem_wdata), 64'(d));
            check({tag, "_busy_done"}, {62'd0, bus.req1_done, bus.req0_done}, 64'd0);
            check({tag, "_busy_ready"}, 64'(get_ready(w)), 64'(!pend(w)));
            if (n == drop_at) begin
                clear_port(w);
                p_addr[w] = $urandom;
                apply_reqs();
            end
            rdy = (n == lat);
            bus.mem_ready = rdy;
            bus.mem_rdata = rdy ? rdv : {$urandom, $urandom};
            if (rdy || n == TIMEOUT) fin = 1'b1;
        end
        timed = (n != lat);
        tick();
        bus.mem_ready = 1'b0;
        if (timed) exp_err = 1'b1;
        else if (!wr) exp_rdata[w] = rdv;
        check({tag, "_done_owner"}, 64'(get_done(w)), 64'd1);
        check({tag, "_done_other"}, 64'(get_done(1 - w)), 64'd0);
        check({tag, "_rel_grant"}, 64'(grant), 64'd0);
        check({tag, "_rel_en"}, {62'd0, bus.mem_rd_en, bus.mem_wr_en}, 64'd0);
        check({tag, "_rel_ready"}, 64'(get_ready(w)), 64'd1);
        check({tag, "_rdata0"}, bus.req0_rdata, exp_rdata[0]);
        check({tag, "_rdata1"}, bus.req1_rdata, exp_rdata[1]);
        check({tag, "_err"}, 64'(err_timeout), 64'(exp_err));
    endtask

    // Moves from RELEASE into IDLE and confirms the completion pulse ended
    task automatic to_idle(input string tag);
        tick();
        check({tag, "_idle_done"}, {62'd0, bus.req1_done, bus.req0_done}, 64'd0);
    endtask

    task automatic idle_cycles(input string tag, input int k);
        for (int i = 0; i < k; i++) begin
            tick();
            check({tag, "_idle_grant"}, 64'(grant), 64'd0);
            check({tag, "_idle_en"}, {62'd0, bus.mem_rd_en, bus.mem_wr_en}, 64'd0);
        end
    endtask

    task automatic random_req(input int p);
        int kind;
        kind = $urandom_range(0, 2);
        p_rd[p]    = (kind != 1);
        p_wr[p]    = (kind != 0);
        p_addr[p]  = $urandom;
        p_wdata[p] = $urandom;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat, drop;
        logic [1:0] seq [4];
        clear_port(0);
        clear_port(1);
        apply_reqs();
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;

        // Scenario 1: uncontended read from port 0
        #3;
        do_reset("rst");
        p_rd[0] = 1'b1; p_addr[0] = 32'h0000_0400;
        apply_reqs();
        run_txn("t1", 7, 0, 64'h1122_3344_5566_7788);
        check("t1_rdata_value", bus.req0_rdata, 64'h1122_3344_5566_7788);
        clear_port(0); apply_reqs();
        to_idle("t1");

        // Scenario 2: write from port 1
        p_wr[1] = 1'b1; p_addr[1] = 32'h404; p_wdata[1] = 32'hDEAD_BEEF;
        apply_reqs();
        run_txn("t2", 5, 0, 64'hFFFF_0000_FFFF_0000);
        clear_port(1); apply_reqs();
        to_idle("t2");

        // Scenario 3: continuous contention from reset alternates grants
        do_reset("rst3");
        p_rd[0] = 1'b1; p_addr[0] = 32'h100;
        p_rd[1] = 1'b1; p_addr[1] = 32'h200;
        apply_reqs();
        for (int i = 0; i < 4; i++) begin
            run_txn("t3", 3 + i, 0, {$urandom, $urandom});
            seq[i] = obs_grant;
            p_addr[last_port] = p_addr[last_port] + 32'h8;
            apply_reqs();
            to_idle("t3");
        end
        check("t3_seq0", 64'(seq[0]), 64'd1);
        check("t3_seq1", 64'(seq[1]), 64'd2);
        check("t3_seq2", 64'(seq[2]), 64'd1);
        check("t3_seq3", 64'(seq[3]), 64'd2);
        clear_port(0); clear_port(1); apply_reqs();
        idle_cycles("t3", 2);

        // Scenario 4: read and write together on one port performs the write
        p_rd[0] = 1'b1; p_wr[0] = 1'b1; p_addr[0] = 32'h808; p_wdata[0] = 32'h1234_5678;
        apply_reqs();
        run_txn("t4", 4, 0, {$urandom, $urandom});
        clear_port(0); apply_reqs();
        to_idle("t4");

        // Scenario 5: controller never ready, then a normal transaction keeps the flag
        p_rd[1] = 1'b1; p_addr[1] = 32'hC00;
        apply_reqs();
        run_txn("t5_to", 0, 0, {$urandom, $urandom});
        clear_port(1); apply_reqs();
        to_idle("t5");
        p_rd[0] = 1'b1; p_addr[0] = 32'hC40;
        apply_reqs();
        run_txn("t5_after", 3, 0, {$urandom, $urandom});
        clear_port(0); apply_reqs();
        to_idle("t5b");

        // Scenario 6: reset in the 4th BUSY cycle, then port 0 wins against pending port 1
        p_rd[1] = 1'b1; p_addr[1] = 32'hE00;
        apply_reqs();
        for (int i = 0; i < 4; i++) tick();
        check("t6_busy_before_reset", 64'(grant), 64'd2);
        p_rd[0] = 1'b1; p_addr[0] = 32'hF00;
        apply_reqs();
        do_reset("t6_rst");
        run_txn("t6", 6, 0, {$urandom, $urandom});
        check("t6_first_grant", 64'(obs_grant), 64'd1);
        clear_port(0); apply_reqs();
        to_idle("t6");
        run_txn("t6b", 2, 0, {$urandom, $urandom});
        clear_port(1); apply_reqs();
        to_idle("t6b");

        // Randomized traffic
        for (int t = 0; t < 60; t++) begin
            for (int p = 0; p < 2; p++)
                if (!pend(p) && ($urandom_range(0, 1) == 1)) random_req(p);
            if (!pend(0) && !pend(1)) begin
                apply_reqs();
                idle_cycles("rnd", $urandom_range(1, 3));
                random_req($urandom_range(0, 1));
            end
            apply_reqs();
            lat = $urandom_range(0, 18);
            if (lat == 1) lat = 2;
            drop = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0;
            run_txn("rnd", lat, drop, {$urandom, $urandom});
            if ($urandom_range(0, 1) == 1) random_req(last_port);
            else clear_port(last_port);
            apply_reqs();
            to_idle("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
